// File: rtl/wb_ram_slave.sv
// Wishbone classic slave fronting a word-organised RAM with byte-lane writes,
// programmable wait states and ERR termination for addresses outside the window.
module wb_ram_slave #(
   parameter int                    ADDR_WIDTH  = 32,
   parameter int                    DATA_WIDTH  = 32,
   parameter int                    DEPTH       = 64,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
   parameter int                    WAIT_CYCLES = 1
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic [DATA_WIDTH-1:0]   DAT_I,
   input  logic [ADDR_WIDTH-1:0]   ADR_I,
   output logic [DATA_WIDTH-1:0]   DAT_O,
   input  logic                    WE_I,
   input  logic [DATA_WIDTH/8-1:0] SEL_I,
   input  logic                    STB_I,
   input  logic                    CYC_I,
   output logic                    ACK_O,
   output logic                    ERR_O
);

   // state  | meaning
   // S_IDLE | waiting for CYC_I & STB_I; request fields latched when seen
   // S_WAIT | counting down wait states; a dropped request aborts to idle
   // S_TERM | ACK_O or ERR_O high for this single cycle, then back to idle

   localparam int                  IDX_W    = $clog2(DEPTH);
   localparam int                  NB       = DATA_WIDTH / 8;
   localparam logic [ADDR_WIDTH:0] LIMIT    = {1'b0, BASE_ADDR} + (ADDR_WIDTH+1)'(4 * DEPTH);
   localparam logic [3:0]          CNT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_TERM} state_t;

   state_t                  r_state;
   logic [3:0]              r_cnt;
   logic [IDX_W-1:0]        r_idx;
   logic [DATA_WIDTH-1:0]   r_dat;
   logic                    r_we;
   logic [NB-1:0]           r_sel;
   logic                    r_hit;
   logic [DATA_WIDTH-1:0]   r_mem [DEPTH];

   logic                    w_req;
   logic                    w_hit_in;
   logic [IDX_W-1:0]        w_idx_in;
   logic                    w_term;
   logic [IDX_W-1:0]        w_idx;
   logic [DATA_WIDTH-1:0]   w_dat;
   logic                    w_we;
   logic [NB-1:0]           w_sel;
   logic                    w_hit;

   assign w_req    = CYC_I & STB_I;
   assign w_idx_in = ADR_I[IDX_W+1:2];
   // Widened upper bound so a window ending at the top of the address space cannot wrap.
   assign w_hit_in = (ADR_I >= BASE_ADDR) && ({1'b0, ADR_I} < LIMIT);

   // Fields used on the edge entering TERM: live inputs for zero-wait, latched otherwise.
   always_comb begin
      w_term = 1'b0;
      w_idx  = r_idx;
      w_dat  = r_dat;
      w_we   = r_we;
      w_sel  = r_sel;
      w_hit  = r_hit;
      case (r_state)
         S_IDLE: begin
            if (WAIT_CYCLES == 0) begin
               w_term = w_req;
               w_idx  = w_idx_in;
               w_dat  = DAT_I;
               w_we   = WE_I;
               w_sel  = SEL_I;
               w_hit  = w_hit_in;
            end
         end
         S_WAIT:  w_term = w_req && (r_cnt == 4'd0);
         default: w_term = 1'b0;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state <= S_IDLE;
         r_cnt   <= 4'd0;
         r_idx   <= '0;
         r_dat   <= '0;
         r_we    <= 1'b0;
         r_sel   <= '0;
         r_hit   <= 1'b0;
         ACK_O   <= 1'b0;
         ERR_O   <= 1'b0;
         DAT_O   <= '0;
      end else begin
         ACK_O <= 1'b0;
         ERR_O <= 1'b0;
         if (r_state == S_IDLE && w_req) begin
            r_idx <= w_idx_in;
            r_dat <= DAT_I;
            r_we  <= WE_I;
            r_sel <= SEL_I;
            r_hit <= w_hit_in;
         end
         if (w_term) begin
            r_state <= S_TERM;
            ACK_O   <= w_hit;
            ERR_O   <= !w_hit;
            DAT_O   <= (w_hit && !w_we) ? r_mem[w_idx] : '0;
         end else begin
            case (r_state)
               S_IDLE: begin
                  if (w_req) begin
                     r_state <= S_WAIT;
                     r_cnt   <= CNT_LOAD;
                  end
               end
               S_WAIT: begin
                  if (!w_req) r_state <= S_IDLE;
                  else        r_cnt   <= r_cnt - 4'd1;
               end
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

   // Storage is deliberately not reset; writes are blocked while reset is held.
   always_ff @(posedge clk_i) begin
      if (rst_ni && w_term && w_hit && w_we) begin
         for (int b = 0; b < NB; b++) begin
            if (w_sel[b]) r_mem[w_idx][8*b +: 8] <= w_dat[8*b +: 8];
         end
      end
   end

endmodule

// File: tb/tb_wb_ram_slave.sv
// Self-checking bench: three builds (1, 0, 15 wait states) against a cycle-level
// transaction model, plus literal checks of the documented scenarios.
module tb_wb_ram_slave;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [2:0]  cyc_s, stb_s, we_s;
   logic [31:0] adr_s [3];
   logic [31:0] dat_s [3];
   logic [3:0]  sel_s [3];
   logic        ack0, ack1, ack2, err0, err1, err2;
   logic [31:0] dato0, dato1, dato2;
   wire  [2:0]  ack_w = {ack2, ack1, ack0};
   wire  [2:0]  err_w = {err2, err1, err0};

   int n_cmp = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   wb_ram_slave #(.WAIT_CYCLES(1)) u_w1 (
      .clk_i(clk), .rst_ni(rst_n), .DAT_I(dat_s[0]), .ADR_I(adr_s[0]), .DAT_O(dato0),
      .WE_I(we_s[0]), .SEL_I(sel_s[0]), .STB_I(stb_s[0]), .CYC_I(cyc_s[0]),
      .ACK_O(ack0), .ERR_O(err0));
   wb_ram_slave #(.WAIT_CYCLES(0)) u_w0 (
      .clk_i(clk), .rst_ni(rst_n), .DAT_I(dat_s[1]), .ADR_I(adr_s[1]), .DAT_O(dato1),
      .WE_I(we_s[1]), .SEL_I(sel_s[1]), .STB_I(stb_s[1]), .CYC_I(cyc_s[1]),
      .ACK_O(ack1), .ERR_O(err1));
   wb_ram_slave #(.WAIT_CYCLES(15)) u_w15 (
      .clk_i(clk), .rst_ni(rst_n), .DAT_I(dat_s[2]), .ADR_I(adr_s[2]), .DAT_O(dato2),
      .WE_I(we_s[2]), .SEL_I(sel_s[2]), .STB_I(stb_s[2]), .CYC_I(cyc_s[2]),
      .ACK_O(ack2), .ERR_O(err2));

   function automatic int wc(input int k);
      return (k == 0) ? 1 : (k == 1) ? 0 : 15;
   endfunction

   function automatic logic [31:0] dato(input int k);
      return (k == 0) ? dato0 : (k == 1) ? dato1 : dato2;
   endfunction

   // ---------------- reference model (transaction level) ----------------
   int          cycle = 0;
   int          start [3];
   int          lastterm [3];
   bit          pend [3];
   logic [31:0] l_adr [3];
   logic [31:0] l_dat [3];
   logic        l_we [3];
   logic [3:0]  l_sel [3];
   logic [31:0] mm [3][64];
   logic [3:0]  mv [3][64];
   logic        e_ack [3];
   logic        e_err [3];
   logic [31:0] e_dat [3];
   bit          e_known [3];

   task automatic apply(input int k);
      int idx;
      idx = int'(l_adr[k][7:2]);
      lastterm[k] = cycle;
      e_known[k] = 1'b1;
      if (l_adr[k] >= 32'h100) begin
         e_err[k] = 1'b1;
         e_dat[k] = '0;
      end else if (l_we[k]) begin
         for (int b = 0; b < 4; b++) begin
            if (l_sel[k][b]) begin
               mm[k][idx][8*b +: 8] = l_dat[k][8*b +: 8];
               mv[k][idx][b] = 1'b1;
            end
         end
         e_ack[k] = 1'b1;
         e_dat[k] = '0;
      end else begin
         e_ack[k] = 1'b1;
         e_dat[k] = mm[k][idx];
         e_known[k] = (mv[k][idx] == 4'hF);
      end
   endtask

   initial begin
      for (int k = 0; k < 3; k++) begin
         pend[k] = 1'b0; lastterm[k] = -10; start[k] = 0;
         e_ack[k] = 1'b0; e_err[k] = 1'b0; e_dat[k] = '0; e_known[k] = 1'b1;
         for (int i = 0; i < 64; i++) begin
            mv[k][i] = 4'h0;
            mm[k][i] = '0;
         end
      end
      forever begin
         @(posedge clk);
         cycle++;
         for (int k = 0; k < 3; k++) begin
            e_ack[k] = 1'b0;
            e_err[k] = 1'b0;
            if (!rst_n) begin
               pend[k] = 1'b0; lastterm[k] = -10;
               e_dat[k] = '0; e_known[k] = 1'b1;
            end else if (pend[k]) begin
               if (!(cyc_s[k] && stb_s[k]))  pend[k] = 1'b0;
               else if (cycle == start[k] + wc(k)) begin
                  apply(k);
                  pend[k] = 1'b0;
               end
            end else if (cyc_s[k] && stb_s[k] && cycle >= lastterm[k] + 2) begin
               l_adr[k] = adr_s[k]; l_dat[k] = dat_s[k];
               l_we[k] = we_s[k];   l_sel[k] = sel_s[k];
               start[k] = cycle;
               if (wc(k) == 0) apply(k);
               else            pend[k] = 1'b1;
            end
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   initial begin
      forever begin
         @(negedge clk);
         for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (ack_w[k] !== e_ack[k]) begin
               n_fail++;
               $display("FAIL ack k=%0d t=%0t got %b want %b", k, $time, ack_w[k], e_ack[k]);
            end
            n_cmp++;
            if (err_w[k] !== e_err[k]) begin
               n_fail++;
               $display("FAIL err k=%0d t=%0t got %b want %b", k, $time, err_w[k], e_err[k]);
            end
            if (e_known[k]) begin
               n_cmp++;
               if (dato(k) !== e_dat[k]) begin
                  n_fail++;
                  $display("FAIL dat k=%0d t=%0t got %h want %h", k, $time, dato(k), e_dat[k]);
               end
            end
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s got %h want %h", name, act, exp);
      end
   endtask

   task automatic xfer(input int k, input logic we, input logic [31:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel, input bit cont, input bit scramble,
                       output logic [31:0] rd, output int lat, output logic a, output logic e);
      if (!cont) begin
         cyc_s[k] = 1'b0; stb_s[k] = 1'b0;
         @(negedge clk);
      end
      adr_s[k] = adr; dat_s[k] = dat; we_s[k] = we; sel_s[k] = sel;
      cyc_s[k] = 1'b1; stb_s[k] = 1'b1;
      lat = 0; a = 1'b0; e = 1'b0;
      while (lat < 40) begin
         @(negedge clk);
         lat++;
         a = ack_w[k];
         e = err_w[k];
         if (a || e) break;
         if (scramble && lat >= (cont ? 2 : 1)) begin
            adr_s[k] = $urandom; dat_s[k] = $urandom;
            we_s[k] = 1'($urandom); sel_s[k] = 4'($urandom);
         end
      end
      if (!(a || e)) begin
         n_cmp++;
         n_fail++;
         $display("FAIL timeout k=%0d adr=%h got no termination want ACK or ERR", k, adr);
      end
      rd = dato(k);
   endtask

   task automatic abort_xfer(input int k, input logic [31:0] adr, input logic [31:0] dat, input int d);
      cyc_s[k] = 1'b0; stb_s[k] = 1'b0;
      @(negedge clk);
      adr_s[k] = adr; dat_s[k] = dat; we_s[k] = 1'b1; sel_s[k] = 4'hF;
      cyc_s[k] = 1'b1; stb_s[k] = 1'b1;
      repeat (d) @(negedge clk);
      cyc_s[k] = 1'b0; stb_s[k] = 1'b0;
      @(negedge clk);
   endtask

   function automatic logic [31:0] rand_adr();
      case ($urandom_range(0, 7))
         0:       return 32'h100 + {22'd0, 8'($urandom)};
         1:       return 32'hFFFF_FF00 | {24'd0, 8'($urandom)};
         2:       return $urandom | 32'h8000_0000;
         default: return {24'd0, 8'($urandom)};
      endcase
   endfunction

   // ---------------- main sequence ----------------
   logic [31:0] rd;
   int          lat;
   logic        a, e;

   initial begin
      cyc_s = '0; stb_s = '0; we_s = '0;
      for (int k = 0; k < 3; k++) begin
         adr_s[k] = '0; dat_s[k] = '0; sel_s[k] = '0;
      end
      adr_s[0] = 32'h10; dat_s[0] = 32'hDEAD_BEEF; we_s[0] = 1'b1; sel_s[0] = 4'hF;
      cyc_s[0] = 1'b1; stb_s[0] = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_ack", {31'd0, ack0}, 32'd0);
      chk("rst_err", {31'd0, err0}, 32'd0);
      chk("rst_dat", dato0, 32'd0);
      rst_n = 1'b1;

      xfer(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 1'b1, 1'b0, rd, lat, a, e);
      chk("wr10_lat", lat, 32'd2);
      chk("wr10_ack", {31'd0, a}, 32'd1);
      xfer(0, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0, 1'b0, rd, lat, a, e);
      chk("rd10_dat", rd, 32'hDEAD_BEEF);
      chk("rd10_ack", {31'd0, a}, 32'd1);

      xfer(0, 1'b1, 32'h20, 32'h1122_3344, 4'hF, 1'b0, 1'b0, rd, lat, a, e);
      xfer(0, 1'b1, 32'h20, 32'hAABB_CCDD, 4'b0101, 1'b0, 1'b0, rd, lat, a, e);
      xfer(0, 1'b0, 32'h20, 32'h0, 4'hF, 1'b0, 1'b0, rd, lat, a, e);
      chk("lanes_dat", rd, 32'h11BB_33DD);
      xfer(0, 1'b1, 32'h20, 32'hFFFF_FFFF, 4'h0, 1'b0, 1'b0, rd, lat, a, e);
      chk("sel0_ack", {31'd0, a}, 32'd1);
      xfer(0, 1'b0, 32'h20, 32'h0, 4'hF, 1'b0, 1'b0, rd, lat, a, e);
      chk("sel0_dat", rd, 32'h11BB_33DD);

      xfer(0, 1'b1, 32'h0, 32'hCAFE_F00D, 4'hF, 1'b0, 1'b0, rd, lat, a, e);
      xfer(0, 1'b0, 32'h100, 32'h0, 4'hF, 1'b0, 1'b0, rd, lat, a, e);
      chk("rd100_err", {30'd0, a, e}, 32'd1);
      chk("rd100_dat", rd, 32'd0);
      xfer(0, 1'b1, 32'h1FC, 32'h1234_5678, 4'hF, 1'b0, 1'b0, rd, lat, a, e);
      chk("wr1fc_err", {30'd0, a, e}, 32'd1);
      xfer(0, 1'b0, 32'h0, 32'h0, 4'hF, 1'b0, 1'b0, rd, lat, a, e);
      chk("word0_dat", rd, 32'hCAFE_F00D);

      xfer(0, 1'b1, 32'h04, 32'h1234_5678, 4'hF, 1'b0, 1'b0, rd, lat, a, e);
      abort_xfer(0, 32'h04, 32'h5555_5555, 1);
      xfer(0, 1'b0, 32'h04, 32'h0, 4'hF, 1'b0, 1'b0, rd, lat, a, e);
      chk("abort_dat", rd, 32'h1234_5678);
      cyc_s[0] = 1'b0; stb_s[0] = 1'b0;

      for (int k = 1; k < 3; k++) begin
         for (int i = 0; i < 4; i++) begin
            xfer(k, 1'b1, 32'(4 * i), 32'(i), 4'hF, i != 0, 1'b0, rd, lat, a, e);
            chk($sformatf("b2b_wr_lat k%0d i%0d", k, i), lat, 32'(wc(k) + (i == 0 ? 1 : 2)));
            chk($sformatf("b2b_wr_ack k%0d i%0d", k, i), {31'd0, a}, 32'd1);
         end
         for (int i = 0; i < 4; i++) begin
            xfer(k, 1'b0, 32'(4 * i), 32'h0, 4'hF, 1'b1, 1'b0, rd, lat, a, e);
            chk($sformatf("b2b_rd_lat k%0d i%0d", k, i), lat, 32'(wc(k) + 2));
            chk($sformatf("b2b_rd_dat k%0d i%0d", k, i), rd, 32'(i));
         end
         xfer(k, 1'b0, 32'h03, 32'h0, 4'h0, 1'b1, 1'b0, rd, lat, a, e);
         chk($sformatf("adr03_dat k%0d", k), rd, 32'd0);
         cyc_s[k] = 1'b0; stb_s[k] = 1'b0;
      end

      for (int k = 0; k < 3; k++) begin
         for (int n = 0; n < ((k == 2) ? 50 : 200); n++) begin
            if ($urandom_range(0, 9) == 0 && wc(k) > 0)
               abort_xfer(k, rand_adr(), $urandom, $urandom_range(1, wc(k)));
            else
               xfer(k, 1'($urandom), rand_adr(), $urandom, 4'($urandom),
                    1'($urandom), 1'b1, rd, lat, a, e);
         end
         cyc_s[k] = 1'b0; stb_s[k] = 1'b0;
      end

      repeat (4) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
